ale_reciprocal_sequencer: RTL and testbench

Sequences the atmospheric-light reciprocal lookup between Atmospheric Light Estimation (ALE) and the transmission and scene-recovery stages. It captures the per-channel atmospheric light (A_R, A_G, A_B) produced at the end of each frame. It time-multiplexes one shared 256-entry Q0.14 reciprocal LUT across the three channels and stages the results in shadow registers. The staged set is committed to the downstream stages only on a frame boundary, so 1/Ac never changes mid-frame.

---
 rtl/ale_reciprocal_sequencer.sv | 126 ++++++++++++
 tb/tb_ale_reciprocal_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ale_reciprocal_sequencer.sv
// ale_reciprocal_sequencer: shares one reciprocal LUT across the three atmospheric-light
// channels, stages 1/Ac in shadow registers and commits the set only on a frame boundary.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   ac_valid, ac_r/g/b         per-frame atmospheric light from ALE (single-cycle pulse)
//   frame_start                single-cycle pulse at the first pixel of a frame
//   lut_addr / lut_data        shared combinational reciprocal LUT (Q0.14)
//   inv_r/g/b                  committed 1/Ac per channel
//   ac_r_o/ac_g_o/ac_b_o       committed (clamped) Ac matching inv_*
//   params_valid               a committed set exists
//   params_update              one-cycle pulse after each commit
//   zero_clamped               committed set had at least one zero input
//   busy                       lookup sequence in progress
module ale_reciprocal_sequencer #(
    parameter int LUT_W = 14,
    parameter int AC_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ac_valid,
    input  logic [AC_W-1:0]  ac_r,
    input  logic [AC_W-1:0]  ac_g,
    input  logic [AC_W-1:0]  ac_b,
    input  logic             frame_start,
    output logic [AC_W-1:0]  lut_addr,
    input  logic [LUT_W-1:0] lut_data,
    output logic [LUT_W-1:0] inv_r,
    output logic [LUT_W-1:0] inv_g,
    output logic [LUT_W-1:0] inv_b,
    output logic [AC_W-1:0]  ac_r_o,
    output logic [AC_W-1:0]  ac_g_o,
    output logic [AC_W-1:0]  ac_b_o,
    output logic             params_valid,
    output logic             params_update,
    output logic             zero_clamped,
    output logic             busy
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LK_R   = 3'd1;
    localparam logic [2:0] LK_G   = 3'd2;
    localparam logic [2:0] LK_B   = 3'd3;
    localparam logic [2:0] STAGED = 3'd4;
    logic [2:0]       state, state_nx;
    logic             pend, fs_seen, cap_z, go, commit, restart;
    logic [AC_W-1:0]  pnd_r, pnd_g, pnd_b, cap_r, cap_g, cap_b;
    logic [LUT_W-1:0] sh_r, sh_g, sh_b;
    function automatic logic [AC_W-1:0] clamp(input logic [AC_W-1:0] a);
        return (a == '0) ? AC_W'(1) : a;
    endfunction
    // Every ac_valid lands in the pending register; an idle FSM starts from it
    // on the next edge. A frame_start seen in STAGED is remembered and the
    // commit happens on the following edge; the very first set after reset
    // commits without waiting for a frame boundary.
    always_comb begin
        go       = (state == IDLE) && pend;
        commit   = (state == STAGED) && (!params_valid || fs_seen);
        restart  = (state == STAGED) && params_valid && !fs_seen && !frame_start && ac_valid;
        state_nx = (state == IDLE) ? (pend ? LK_R : IDLE) :
                   (state == LK_R) ? LK_G :
                   (state == LK_G) ? LK_B :
                   (state == LK_B) ? STAGED :
                   (commit || restart) ? IDLE : STAGED;
        lut_addr = (state == LK_R) ? cap_r :
                   (state == LK_G) ? cap_g :
                   (state == LK_B) ? cap_b : '0;
        busy     = (state == LK_R) || (state == LK_G) || (state == LK_B);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            pend          <= 1'b0;
            fs_seen       <= 1'b0;
            pnd_r         <= '0;
            pnd_g         <= '0;
            pnd_b         <= '0;
            cap_r         <= '0;
            cap_g         <= '0;
            cap_b         <= '0;
            cap_z         <= 1'b0;
            sh_r          <= '0;
            sh_g          <= '0;
            sh_b          <= '0;
            inv_r         <= '0;
            inv_g         <= '0;
            inv_b         <= '0;
            ac_r_o        <= '0;
            ac_g_o        <= '0;
            ac_b_o        <= '0;
            params_valid  <= 1'b0;
            params_update <= 1'b0;
            zero_clamped  <= 1'b0;
        end else begin
            state <= state_nx;
            if (ac_valid) begin
                pend  <= 1'b1;
                pnd_r <= ac_r;
                pnd_g <= ac_g;
                pnd_b <= ac_b;
            end else if (go) begin
                pend <= 1'b0;
            end
            if (go) begin
                cap_r <= clamp(pnd_r);
                cap_g <= clamp(pnd_g);
                cap_b <= clamp(pnd_b);
                cap_z <= (pnd_r == '0) || (pnd_g == '0) || (pnd_b == '0);
            end
            if (state == LK_R) sh_r <= lut_data;
            if (state == LK_G) sh_g <= lut_data;
            if (state == LK_B) sh_b <= lut_data;
            fs_seen       <= (state == STAGED) && !commit && (fs_seen || frame_start);
            params_update <= commit;
            if (commit) begin
                inv_r        <= sh_r;
                inv_g        <= sh_g;
                inv_b        <= sh_b;
                ac_r_o       <= cap_r;
                ac_g_o       <= cap_g;
                ac_b_o       <= cap_b;
                zero_clamped <= cap_z;
                params_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ale_reciprocal_sequencer.sv
// tb_ale_reciprocal_sequencer: scoreboard bench for the reciprocal sequencer.
module tb_ale_reciprocal_sequencer;
    logic        clk = 1'b0, rst_n = 1'b0, ac_valid = 1'b0, frame_start = 1'b0;
    logic [7:0]  ac_r = '0, ac_g = '0, ac_b = '0;
    logic [7:0]  lut_addr, ac_r_o, ac_g_o, ac_b_o;
    logic [13:0] lut_data, inv_r, inv_g, inv_b;
    logic        params_valid, params_update, zero_clamped, busy;
    int total = 0, bad = 0, cyc = 0;
    typedef struct packed {
        logic [67:0] v;
        int          tag;
    } exp_t;
    exp_t q[$];

    ale_reciprocal_sequencer #(.LUT_W(14), .AC_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ac_valid(ac_valid), .ac_r(ac_r), .ac_g(ac_g), .ac_b(ac_b),
        .frame_start(frame_start), .lut_addr(lut_addr), .lut_data(lut_data),
        .inv_r(inv_r), .inv_g(inv_g), .inv_b(inv_b), .ac_r_o(ac_r_o), .ac_g_o(ac_g_o), .ac_b_o(ac_b_o),
        .params_valid(params_valid), .params_update(params_update),
        .zero_clamped(zero_clamped), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Q0.14 reciprocal, rounded to nearest and saturated at 16383
    function automatic logic [13:0] recip(input logic [7:0] a);
        int d, v;
        d = (a == 8'd0) ? 1 : int'(a);
        v = (16384 + d / 2) / d;
        return (v > 16383) ? 14'd16383 : v[13:0];
    endfunction

    assign lut_data = recip(lut_addr);

    function automatic logic [67:0] exp_of(input logic [7:0] r, g, b);
        logic [7:0] cr, cg, cb;
        cr = (r == 0) ? 8'd1 : r;
        cg = (g == 0) ? 8'd1 : g;
        cb = (b == 0) ? 8'd1 : b;
        return {recip(cr), recip(cg), recip(cb), cr, cg, cb, (r == 0) || (g == 0) || (b == 0), 1'b1};
    endfunction

    function automatic logic [7:0] rv();
        return ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
    endfunction

    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    task automatic push(input logic [67:0] v, input int tag);
        exp_t e;
        e.v = v;
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic go(input int n);
        while (cyc < n - 1) @(negedge clk);
    endtask

    task automatic ac_at(input int n, input logic [7:0] r, g, b, input logic fs);
        go(n);
        ac_valid = 1'b1;
        ac_r = r;
        ac_g = g;
        ac_b = b;
        frame_start = fs;
        @(negedge clk);
        ac_valid = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic fs_at(input int n);
        go(n);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    // Monitor: pops the expected set on each params_update and checks that the
    // committed outputs otherwise hold their last committed value.
    initial begin
        logic [67:0] held;
        exp_t e;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) held = '0;
            else begin
                if (params_update) begin
                    if (q.size() == 0) chk("spurious_update", 128'(params_update), 128'(0));
                    else begin
                        e = q.pop_front();
                        chk("commit_cycle", 128'(cyc), 128'(e.tag));
                        held = e.v;
                    end
                end
                chk("outputs", 128'({inv_r, inv_g, inv_b, ac_r_o, ac_g_o, ac_b_o, zero_clamped, params_valid}), 128'(held));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int s, s2, f, f2, d, k;
        bit three;
        logic [7:0] a[9];
        repeat (3) @(negedge clk);
        chk("reset_state", 128'({inv_r, inv_g, inv_b, ac_r_o, ac_g_o, ac_b_o, params_valid, params_update, zero_clamped, busy, lut_addr}), 128'(0));
        #2 rst_n = 1'b1;
        @(negedge clk);
        // first set after reset commits without frame_start
        s = cyc + 1;
        push(exp_of(8'd1, 8'd128, 8'd255), s + 5);
        ac_at(s, 8'd1, 8'd128, 8'd255, 1'b0);
        chk("addr_pre", 128'({busy, lut_addr}), 128'({1'b0, 8'd0}));
        @(negedge clk);
        chk("addr_r", 128'({busy, lut_addr}), 128'({1'b1, 8'd1}));
        @(negedge clk);
        chk("addr_g", 128'({busy, lut_addr}), 128'({1'b1, 8'd128}));
        @(negedge clk);
        chk("addr_b", 128'({busy, lut_addr}), 128'({1'b1, 8'd255}));
        @(negedge clk);
        chk("addr_staged", 128'({busy, lut_addr}), 128'({1'b0, 8'd0}));
        go(s + 7);
        // later set waits for frame_start
        s = cyc + 1;
        push(exp_of(8'd200, 8'd200, 8'd200), s + 8);
        ac_at(s, 8'd200, 8'd200, 8'd200, 1'b0);
        fs_at(s + 7);
        go(s + 10);
        // zero clamp
        s = cyc + 1;
        push(exp_of(8'd100, 8'd10, 8'd0), s + 6);
        ac_at(s, 8'd100, 8'd10, 8'd0, 1'b0);
        fs_at(s + 5);
        go(s + 8);
        // second pulse while busy goes to pending
        s = cyc + 1;
        push(exp_of(8'd50, 8'd60, 8'd70), s + 7);
        push(exp_of(8'd20, 8'd21, 8'd22), s + 13);
        ac_at(s, 8'd50, 8'd60, 8'd70, 1'b0);
        ac_at(s + 2, 8'd20, 8'd21, 8'd22, 1'b0);
        fs_at(s + 6);
        fs_at(s + 12);
        go(s + 15);
        // coincident frame_start and ac_valid in STAGED
        s = cyc + 1;
        push(exp_of(8'd30, 8'd30, 8'd30), s + 6);
        push(exp_of(8'd40, 8'd40, 8'd40), s + 12);
        ac_at(s, 8'd30, 8'd30, 8'd30, 1'b0);
        ac_at(s + 5, 8'd40, 8'd40, 8'd40, 1'b1);
        fs_at(s + 11);
        go(s + 14);
        // reset during LK_G
        s = cyc + 1;
        ac_at(s, 8'd9, 8'd9, 8'd9, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("busy_lkg", 128'({busy, lut_addr}), 128'({1'b1, 8'd9}));
        #2 rst_n = 1'b0;
        #1 chk("async_reset", 128'({inv_r, inv_g, inv_b, ac_r_o, ac_g_o, ac_b_o, params_valid, params_update, zero_clamped, busy, lut_addr}), 128'(0));
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) fs_at(cyc + 4);
        go(cyc + 6);
        s = cyc + 1;
        push(exp_of(8'd3, 8'd77, 8'd0), s + 5);
        ac_at(s, 8'd3, 8'd77, 8'd0, 1'b0);
        go(s + 7);
        // randomized transactions
        for (int i = 0; i < 40; i++) begin
            for (int j = 0; j < 9; j++) a[j] = rv();
            k = $urandom_range(0, 3);
            s = cyc + 1;
            if (k == 0) begin
                f = s + 5 + $urandom_range(0, 4);
                push(exp_of(a[0], a[1], a[2]), f + 1);
                ac_at(s, a[0], a[1], a[2], 1'b0);
                fs_at(s + 2);
                fs_at(f);
                go(f + 3);
            end else if (k == 1) begin
                s2 = s + 5 + $urandom_range(0, 3);
                f = s2 + 5 + $urandom_range(0, 3);
                push(exp_of(a[3], a[4], a[5]), f + 1);
                ac_at(s, a[0], a[1], a[2], 1'b0);
                ac_at(s2, a[3], a[4], a[5], 1'b0);
                fs_at(f);
                go(f + 3);
            end else if (k == 2) begin
                d = s + 1 + $urandom_range(0, 2);
                three = 1'($urandom_range(0, 1));
                f = s + 5 + $urandom_range(0, 3);
                f2 = f + 6 + $urandom_range(0, 3);
                push(exp_of(a[0], a[1], a[2]), f + 1);
                push(three ? exp_of(a[6], a[7], a[8]) : exp_of(a[3], a[4], a[5]), f2 + 1);
                ac_at(s, a[0], a[1], a[2], 1'b0);
                ac_at(d, a[3], a[4], a[5], 1'b0);
                if (three) ac_at(d + 1, a[6], a[7], a[8], 1'b0);
                fs_at(f);
                fs_at(f2);
                go(f2 + 3);
            end else begin
                f = s + 5 + $urandom_range(0, 3);
                f2 = f + 6 + $urandom_range(0, 3);
                push(exp_of(a[0], a[1], a[2]), f + 1);
                push(exp_of(a[3], a[4], a[5]), f2 + 1);
                ac_at(s, a[0], a[1], a[2], 1'b0);
                ac_at(f, a[3], a[4], a[5], 1'b1);
                fs_at(f2);
                go(f2 + 3);
            end
        end
        go(cyc + 5);
        chk("queue_drained", 128'(q.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
